// File: rtl/pid_seq_pkg.sv
// Shared types and default timing constants for the PID loop sequencer.
package pid_seq_pkg;

  localparam int unsigned StateWidth       = 3;
  localparam int unsigned DefPipeLatency   = 4;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [StateWidth-1:0] {
    StIdle     = 3'd0,
    StAdcReq   = 3'd1,
    StAdcWait  = 3'd2,
    StPipeWait = 3'd3,
    StDacReq   = 3'd4,
    StDacWait  = 3'd5
  } state_e;

endpackage

// File: rtl/pid_saturate.sv
// Combinational signed clamp from a wide controller output to a narrower DAC code.
module pid_saturate #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 20
) (
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 sat_o
);

  // The value fits iff every bit from the DAC sign bit upward matches.
  logic upper_ones;
  logic upper_zeros;

  assign upper_ones  = &data_i[IN_WIDTH-1:OUT_WIDTH-1];
  assign upper_zeros = ~|data_i[IN_WIDTH-1:OUT_WIDTH-1];

  // Pass through in range, otherwise clamp to the extreme matching the input sign.
  always_comb begin
    sat_o  = 1'b0;
    data_o = data_i[OUT_WIDTH-1:0];
    if (!(upper_ones || upper_zeros)) begin
      sat_o = 1'b1;
      if (data_i[IN_WIDTH-1]) begin
        data_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        data_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/pid_loop_sequencer.sv
// Control-loop sequencer: ADC request, pipeline settle, integral commit, DAC write.
// Owns the integral state; all outputs are registered or decoded from the state register.
module pid_loop_sequencer
  import pid_seq_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH    = 18,
  parameter int unsigned OUTPUT_WIDTH   = 32,
  parameter int unsigned DAC_WIDTH      = 20,
  parameter int unsigned PIPE_LATENCY   = DefPipeLatency,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic                    i_clear_integral,
  input  logic                    i_clear_fault,
  output logic                    o_adc_req,
  input  logic                    i_adc_done,
  input  logic [INPUT_WIDTH-1:0]  i_adc_data,
  output logic [INPUT_WIDTH-1:0]  o_actual,
  output logic [OUTPUT_WIDTH-1:0] o_integral,
  input  logic [OUTPUT_WIDTH-1:0] i_integral_next,
  input  logic [OUTPUT_WIDTH-1:0] i_pd_out,
  output logic                    o_dac_req,
  output logic [DAC_WIDTH-1:0]    o_dac_data,
  input  logic                    i_dac_done,
  output logic                    o_busy,
  output logic                    o_sat,
  output logic                    o_fault,
  output logic [31:0]             o_iterations
);

  localparam int unsigned PipeCntW = (PIPE_LATENCY > 0) ? $clog2(PIPE_LATENCY + 1) : 1;
  localparam int unsigned TmoW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PipeCntW-1:0] PipeLoad = PipeCntW'(PIPE_LATENCY);
  localparam logic [TmoW-1:0]     TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [PipeCntW-1:0]     pipe_cnt_q, pipe_cnt_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic [INPUT_WIDTH-1:0]  actual_q, actual_d;
  logic [OUTPUT_WIDTH-1:0] integral_q, integral_d;
  logic [DAC_WIDTH-1:0]    dac_q, dac_d;
  logic                    sat_q, sat_d;
  logic                    fault_q, fault_d;
  logic [31:0]             iter_q, iter_d;

  logic [DAC_WIDTH-1:0]    sat_data;
  logic                    sat_flag;

  pid_saturate #(
    .IN_WIDTH  (OUTPUT_WIDTH),
    .OUT_WIDTH (DAC_WIDTH)
  ) u_saturate (
    .data_i (i_pd_out),
    .data_o (sat_data),
    .sat_o  (sat_flag)
  );

  // Next-state and datapath updates; defaults hold every register.
  always_comb begin
    state_d    = state_q;
    pipe_cnt_d = pipe_cnt_q;
    tmo_d      = '0;  // shared wait timer restarts on every state entry
    actual_d   = actual_q;
    integral_d = integral_q;
    dac_d      = dac_q;
    sat_d      = sat_q;
    fault_d    = fault_q;
    iter_d     = iter_q;

    if (i_clear_fault) begin
      fault_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (i_enable && !fault_q) begin
          state_d = StAdcReq;
        end
      end
      StAdcReq: begin
        state_d = StAdcWait;
      end
      StAdcWait: begin
        if (i_adc_done) begin
          actual_d   = i_adc_data;
          pipe_cnt_d = PipeLoad;
          state_d    = StPipeWait;
        end else if (tmo_q == TmoLast) begin
          fault_d = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StPipeWait: begin
        if (pipe_cnt_q == '0) begin
          integral_d = i_integral_next;
          dac_d      = sat_data;
          sat_d      = sat_flag;
          state_d    = StDacReq;
        end else if (i_clear_integral) begin
          // Pipeline inputs change with the clear, so wait the full latency again.
          pipe_cnt_d = PipeLoad;
        end else begin
          pipe_cnt_d = pipe_cnt_q - PipeCntW'(1);
        end
      end
      StDacReq: begin
        state_d = StDacWait;
      end
      StDacWait: begin
        if (i_dac_done) begin
          iter_d  = iter_q + 32'd1;
          state_d = i_enable ? StAdcReq : StIdle;
        end else if (tmo_q == TmoLast) begin
          fault_d = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear beats the commit from the pipeline in the same cycle.
    if (i_clear_integral) begin
      integral_d = '0;
    end
  end

  // State and datapath registers; reset aborts any iteration in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      pipe_cnt_q <= '0;
      tmo_q      <= '0;
      actual_q   <= '0;
      integral_q <= '0;
      dac_q      <= '0;
      sat_q      <= 1'b0;
      fault_q    <= 1'b0;
      iter_q     <= '0;
    end else begin
      state_q    <= state_d;
      pipe_cnt_q <= pipe_cnt_d;
      tmo_q      <= tmo_d;
      actual_q   <= actual_d;
      integral_q <= integral_d;
      dac_q      <= dac_d;
      sat_q      <= sat_d;
      fault_q    <= fault_d;
      iter_q     <= iter_d;
    end
  end

  assign o_adc_req    = (state_q == StAdcReq);
  assign o_dac_req    = (state_q == StDacReq);
  assign o_busy       = (state_q != StIdle);
  assign o_actual     = actual_q;
  assign o_integral   = integral_q;
  assign o_dac_data   = dac_q;
  assign o_sat        = sat_q;
  assign o_fault      = fault_q;
  assign o_iterations = iter_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Scoreboard bench: ADC/DAC responders and a pipeline model around the sequencer,
// expectations from a per-iteration reference model, checked by a DAC-request monitor.
module tb_pid_loop_sequencer;

  localparam int IW = 18;
  localparam int OW = 32;
  localparam int DW = 20;
  localparam int PL = 4;
  localparam int TO = 1024;
  localparam int DacMax = (1 << (DW - 1)) - 1;
  localparam int DacMin = -(1 << (DW - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, clr_main, clr_resp, clear_integral, clear_fault;
  logic          adc_req, adc_done, dac_req, dac_done, dac_done_resp, dac_done_force;
  logic [IW-1:0] adc_data, actual;
  logic [OW-1:0] integral, integral_next, pd_out;
  logic [DW-1:0] dac_data;
  logic          busy, sat, fault;
  logic [31:0]   iterations;

  int kp = 0, ki = 0, sp = 0, pipe_err;
  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int integ_ref = 0, iter_ref = 0, dac_req_seen = 0;
  bit adc_silent = 1'b0, clear_on_exit = 1'b0;

  typedef struct {
    int dac;
    bit sat;
    int integ;
    int iter;
    int c0;
  } exp_t;

  exp_t sb[$];
  int   force_q[$];

  assign clear_integral = clr_main | clr_resp;
  assign dac_done       = dac_done_resp | dac_done_force;

  pid_loop_sequencer #(
    .INPUT_WIDTH    (IW),
    .OUTPUT_WIDTH   (OW),
    .DAC_WIDTH      (DW),
    .PIPE_LATENCY   (PL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (enable),
    .i_clear_integral (clear_integral),
    .i_clear_fault    (clear_fault),
    .o_adc_req        (adc_req),
    .i_adc_done       (adc_done),
    .i_adc_data       (adc_data),
    .o_actual         (actual),
    .o_integral       (integral),
    .i_integral_next  (integral_next),
    .i_pd_out         (pd_out),
    .o_dac_req        (dac_req),
    .o_dac_data       (dac_data),
    .i_dac_done       (dac_done),
    .o_busy           (busy),
    .o_sat            (sat),
    .o_fault          (fault),
    .o_iterations     (iterations)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External PI/PD pipeline: error = actual - setpoint, output settles well within PL.
  always_comb begin
    pipe_err      = int'($signed(actual)) - sp;
    integral_next = OW'(int'(integral) + ki * pipe_err);
    pd_out        = OW'(kp * pipe_err + int'(integral_next));
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One loop iteration as plain arithmetic on the controller law.
  function automatic exp_t model_step(input int s, input bit clr);
    exp_t e;
    int err, ni, pd;
    err = s - sp;
    ni  = integ_ref + ki * err;
    pd  = kp * err + ni;
    if (pd > DacMax) begin
      e.dac = DacMax; e.sat = 1'b1;
    end else if (pd < DacMin) begin
      e.dac = DacMin; e.sat = 1'b1;
    end else begin
      e.dac = pd; e.sat = 1'b0;
    end
    integ_ref = clr ? 0 : ni;
    e.integ   = integ_ref;
    e.iter    = iter_ref;
    e.c0      = 0;
    iter_ref++;
    return e;
  endfunction

  // ADC responder: answers each request after a random delay, records the expectation.
  initial begin
    adc_done = 1'b0;
    adc_data = '0;
    clr_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (adc_req && !adc_silent && !rst) begin
        int   s;
        bit   clr;
        exp_t e;
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
        if (force_q.size() > 0) s = force_q.pop_front();
        else s = int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
        adc_data = IW'(s);
        adc_done = 1'b1;
        clr      = clear_on_exit;
        e        = model_step(s, clr);
        @(posedge clk); #1;
        adc_done = 1'b0;
        e.c0     = cyc;
        sb.push_back(e);
        if (clr) begin
          // Hold the clear across the edge that leaves the pipeline wait.
          repeat (PL) begin @(posedge clk); #1; end
          clr_resp = 1'b1;
          @(posedge clk); #1;
          clr_resp      = 1'b0;
          clear_on_exit = 1'b0;
        end
      end
    end
  end

  // DAC responder.
  initial begin
    dac_done_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dac_req && !rst) begin
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
        dac_done_resp = 1'b1;
        @(posedge clk); #1;
        dac_done_resp = 1'b0;
      end
    end
  end

  // Monitor: every DAC request must match the oldest expectation.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && dac_req) begin
        dac_req_seen++;
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_dac_req: got dac_req=1 at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dac_data", longint'($signed(dac_data)), e.dac);
          check("sat", sat, e.sat);
          check("integral", longint'($signed(integral)), e.integ);
          check("iterations_at_dac_req", iterations, e.iter);
          // Edges from the ADC-done capture edge to the edge that samples o_dac_req.
          check("dac_req_latency", cyc + 1 - e.c0, PL + 2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    check(name, busy, 0);
  endtask

  task automatic wait_iters(input string name, input int target, input int budget);
    int n = 0;
    while (iterations != 32'(target) && n < budget) begin step(); n++; end
    check(name, iterations, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_adc_req"}, adc_req, 0);
    check({tag, "_dac_req"}, dac_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sat"}, sat, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_actual"}, actual, 0);
    check({tag, "_integral"}, integral, 0);
    check({tag, "_dac_data"}, dac_data, 0);
    check({tag, "_iterations"}, iterations, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ca, seen0, it0;
    rst = 1'b1; enable = 1'b0; clr_main = 1'b0; clear_fault = 1'b0; dac_done_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // kp=1, ki=0, setpoint 100, sample 150 -> 50.
    kp = 1; ki = 0; sp = 100;
    force_q.push_back(150);
    enable = 1'b1;
    step();
    check("adc_req_after_enable", adc_req, 1);
    enable = 1'b0;
    wait_idle("t1_idle", 100);
    check("t1_dac_data", longint'($signed(dac_data)), 50);
    check("t1_sat", sat, 0);
    check("t1_iterations", iterations, 1);

    // Pure integrator: three samples of 10 accumulate to 30.
    kp = 0; ki = 1; sp = 0;
    clr_main = 1'b1; step(); clr_main = 1'b0;
    integ_ref = 0;
    check("t2_cleared", integral, 0);
    repeat (3) force_q.push_back(10);
    enable = 1'b1;
    wait_iters("t2_iters", 3, 200);
    enable = 1'b0;
    wait_idle("t2_idle", 100);
    check("t2_iterations", iterations, 4);
    check("t2_integral", longint'($signed(integral)), 30);
    check("t2_dac_data", longint'($signed(dac_data)), 30);

    // Saturation at both rails.
    kp = 4096; ki = 0; sp = 0;
    force_q.push_back(1000);
    force_q.push_back(-1000);
    enable = 1'b1;
    wait_iters("t3_iters", 5, 200);
    enable = 1'b0;
    wait_idle("t3_idle", 100);
    check("t3_dac_min", longint'($signed(dac_data)), DacMin);
    check("t3_sat", sat, 1);

    // Randomized gains, setpoint and samples.
    for (int r = 0; r < 2; r++) begin
      kp = int'($urandom_range(0, 8));
      ki = int'($urandom_range(0, 3));
      sp = int'($urandom_range(0, 2000)) - 1000;
      enable = 1'b1;
      wait_iters("rand_iters", iter_ref + 10, 600);
      enable = 1'b0;
      wait_idle("rand_idle", 100);
      check("rand_iterations", iterations, iter_ref);
      check("rand_sb_empty", sb.size(), 0);
    end

    // ADC never answers: timeout, fault, restart blocked until cleared.
    adc_silent = 1'b1;
    seen0 = dac_req_seen;
    it0   = int'(iterations);
    enable = 1'b1;
    n = 0;
    while (!adc_req && n < 5) begin step(); n++; end
    check("t4_adc_req", adc_req, 1);
    ca = cyc;
    n = 0;
    while (!fault && n < TO + 50) begin step(); n++; end
    check("t4_fault", fault, 1);
    check("t4_fault_cycle", cyc - ca, TO + 1);
    repeat (5) step();
    check("t4_idle", busy, 0);
    check("t4_blocked", adc_req, 0);
    check("t4_no_dac_req", dac_req_seen, seen0);
    check("t4_iterations", iterations, it0);

    // Clear fault with enable high; this iteration also clears the integral on commit.
    kp = 1; ki = 1; sp = 0;
    force_q.push_back(500);
    clear_on_exit = 1'b1;
    adc_silent    = 1'b0;
    clear_fault   = 1'b1; step(); clear_fault = 1'b0;
    check("t5_fault_cleared", fault, 0);
    step();
    check("t5_adc_req", adc_req, 1);
    n = 0;
    while (!dac_req && n < 50) begin step(); n++; end
    step();
    enable = 1'b0;  // now in the DAC wait
    wait_idle("t5_idle", 100);
    check("t5_integral", integral, 0);
    check("t5_iterations", iterations, it0 + 1);
    repeat (4) step();
    check("t5_stays_idle", busy, 0);

    // Reset during the pipeline wait aborts; a late DAC done is ignored.
    kp = 1; ki = 0; sp = 0;
    seen0 = dac_req_seen;
    enable = 1'b1;
    n = 0;
    while (!adc_done && n < 50) begin @(negedge clk); n++; end
    check("t6_adc_done_seen", adc_done, 1);
    @(posedge clk); #2;
    rst = 1'b1; enable = 1'b0;
    #1;
    check_all_zero("t6_reset");
    sb.delete();
    integ_ref = 0; iter_ref = 0;
    step(); step();
    rst = 1'b0;
    dac_done_force = 1'b1; step(); dac_done_force = 1'b0;
    repeat (3) step();
    check("t6_iterations", iterations, 0);
    check("t6_busy", busy, 0);
    check("t6_no_dac_req", dac_req_seen, seen0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pid_loop_sequencer.md
# pid_loop_sequencer

Control-loop sequencer for the PD/PI pipeline datapath: requests an ADC conversion, presents the sample and held integral state to the pipeline, waits out the pipeline latency, commits the updated integral, and writes the saturated controller output to the DAC. It sits between the ADC/DAC SPI masters and the pipeline, and owns the only copy of the integral state. Gains and setpoint bypass it and go straight to the pipeline.

## Interface
- INPUT_WIDTH, 18, ADC sample / pipeline input width (signed)
- OUTPUT_WIDTH, 32, pipeline output and integral width (signed)
- DAC_WIDTH, 20, DAC code width (signed two's complement)
- PIPE_LATENCY, 4, edges from pipeline input sampling to valid pipeline output
- TIMEOUT_CYCLES, 1024, max cycles waiting on ADC or DAC done
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  run loop continuously while high
- i_clear_integral  in  1  zero integral state
- i_clear_fault  in  1  clear sticky fault
- o_adc_req  out  1  one-cycle conversion request
- i_adc_done  in  1  one-cycle conversion-complete strobe
- i_adc_data  in  INPUT_WIDTH  sample, valid with i_adc_done
- o_actual  out  INPUT_WIDTH  held sample to pipeline
- o_integral  out  OUTPUT_WIDTH  held integral state to pipeline
- i_integral_next  in  OUTPUT_WIDTH  updated integral from pipeline
- i_pd_out  in  OUTPUT_WIDTH  controller output from pipeline
- o_dac_req  out  1  one-cycle DAC write request
- o_dac_data  out  DAC_WIDTH  saturated DAC code, held until next commit
- i_dac_done  in  1  one-cycle DAC write-complete strobe
- o_busy  out  1  high in any state except IDLE
- o_sat  out  1  last commit was clamped
- o_fault  out  1  sticky timeout flag
- o_iterations  out  32  completed loop iterations, wraps

## Operation
- States: IDLE, ADC_REQ, ADC_WAIT, PIPE_WAIT, DAC_REQ, DAC_WAIT.
- IDLE -> ADC_REQ when i_enable=1 and o_fault=0.
- ADC_REQ: o_adc_req=1 for exactly this cycle; -> ADC_WAIT.
- ADC_WAIT: i_adc_done sampled only here; on done, o_actual <= i_adc_data, -> PIPE_WAIT. Done outside ADC_WAIT ignored.
- PIPE_WAIT: held PIPE_LATENCY+1 cycles (down-counter); o_actual, o_integral frozen. On exit edge: o_integral <= i_integral_next, o_dac_data <= sat(i_pd_out), o_sat updated; -> DAC_REQ.
- DAC_REQ: o_dac_req=1 one cycle; -> DAC_WAIT.
- DAC_WAIT: on i_dac_done, o_iterations += 1; -> ADC_REQ if i_enable else IDLE.
- i_enable low mid-iteration: current iteration completes, then IDLE.
- Saturation: i_pd_out > 2^(DAC_WIDTH-1)-1 -> max code; < -2^(DAC_WIDTH-1) -> min code; else low DAC_WIDTH bits. o_sat=1 iff clamped.
- i_clear_integral: o_integral <= 0 next edge in any state; wins over PIPE_WAIT exit commit in same cycle (dac data still committed). While in PIPE_WAIT, cleared value is what the pipeline sees, so the counter restarts.
- Timeout: ADC_WAIT or DAC_WAIT exceeding TIMEOUT_CYCLES -> o_fault=1, -> IDLE; integral and o_dac_data unchanged, o_iterations not incremented. Fault blocks restart until i_clear_fault (takes effect next edge; simultaneous fault set wins).

## Timing
- Reset: state IDLE; all outputs 0 (o_adc_req, o_dac_req, o_busy, o_sat, o_fault, o_actual, o_integral, o_dac_data, o_iterations). Reset mid-iteration aborts immediately; any in-flight strobe is ignored afterwards.
- i_enable rise -> o_adc_req high on the cycle after the sampling edge.
- Edge capturing i_adc_done -> o_dac_req high PIPE_LATENCY+2 edges later (6 at defaults).
- All outputs registered; no combinational input-to-output paths.

## Structure
- Package pid_seq_pkg: state enum, state encoding width, default PIPE_LATENCY/TIMEOUT_CYCLES constants.
- Sub-module pid_saturate: combinational OUTPUT_WIDTH->DAC_WIDTH signed clamp with sat flag; instantiated once.
- Timeout counter shared between ADC_WAIT and DAC_WAIT, cleared on every state entry.

## Test plan
- Pipeline with kp=1, ki=0, setpoint=100; ADC returns 150 -> o_dac_data=50, o_sat=0, o_iterations=1, o_dac_req 6 cycles after done.
- kp=0, ki=1, setpoint=0, ADC returns 10 for three iterations -> o_integral 10, 20, 30; o_dac_data 10, 20, 30.
- kp=4096, error=1000 -> o_dac_data=524287, o_sat=1; error=-1000 -> -524288, o_sat=1.
- ADC never answers -> o_fault=1 after 1024 wait cycles, IDLE, no o_dac_req; i_clear_fault with enable high -> new o_adc_req.
- i_clear_integral pulsed on PIPE_WAIT exit cycle -> o_integral=0, o_dac_data still committed; i_enable dropped in DAC_WAIT -> returns to IDLE after done.
- i_rst asserted in PIPE_WAIT -> all outputs 0 immediately; late i_dac_done ignored, o_iterations stays 0.
